ptp_pulse_capture: RTL and testbench

- Timestamps edges of an external pulse input, such as a GPS/PPS or peer PPS, against the local 96-bit PTP ToD clock.
- It is the receive-side counterpart of the periodic pulse generator, and sits beside it on the PTP clock domain.
- Each event is latency-compensated and buffered in a small FIFO, then presented on a valid/ready stream for software/DMA readout.

---
 rtl/ptp_pkg.sv | 32 +++
 rtl/ptp_capture_fifo.sv | 62 ++++++
 rtl/ptp_pulse_capture.sv | 158 +++++++++++++++
 tb/tb_ptp_pulse_capture.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_pkg.sv
// Shared PTP time-of-day definitions: 96-bit ToD layout and helpers.
package ptp_pkg;

  localparam int unsigned NS_PER_S = 1_000_000_000;

  // ToD layout: [95:48] seconds, [47:46] reserved zero, [45:16] ns, [15:0] fractional ns
  localparam int unsigned TS_W   = 96;
  localparam int unsigned S_MSB  = 95;
  localparam int unsigned S_LSB  = 48;
  localparam int unsigned NS_MSB = 45;
  localparam int unsigned NS_LSB = 16;
  localparam int unsigned FNS_W  = 16;
  localparam int unsigned S_W    = S_MSB - S_LSB + 1;
  localparam int unsigned NS_W   = NS_MSB - NS_LSB + 1;

  typedef logic [TS_W-1:0]  ts96_t;
  typedef logic [S_W-1:0]   tod_s_t;
  typedef logic [NS_W-1:0]  tod_ns_t;
  typedef logic [FNS_W-1:0] tod_fns_t;

  // One captured event as stored in the event FIFO
  typedef struct packed {
    logic  rise;
    ts96_t ts;
  } ts_event_t;

  // Assemble a ToD word with the reserved bits forced to zero
  function automatic ts96_t ts96_pack(tod_s_t s, tod_ns_t ns, tod_fns_t fns);
    return {s, 2'b00, ns, fns};
  endfunction

endpackage

// File: rtl/ptp_capture_fifo.sv
// Synchronous first-word-fall-through FIFO for captured PTP events.
module ptp_capture_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 97
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign do_rd = pop & ~empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted
  assign do_wr = push & (~full | do_rd);

  // Head entry is presented only while valid so idle outputs read as zero
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ptp_pulse_capture.sv
// Timestamps edges of an external pulse against the local PTP ToD, compensates the
// synchronizer/detect latency and buffers events on a valid/ready stream.
module ptp_pulse_capture
  import ptp_pkg::*;
#(
  parameter int unsigned FNS_ENABLE  = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [29:0] COMP_NS     = 30'd24,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] input_ts_96,
  input  logic        input_ts_step,
  input  logic        pulse_in,
  input  logic        enable,
  input  logic [1:0]  edge_sel,
  input  logic        clear,
  output logic [95:0] m_axis_ts_tdata,
  output logic        m_axis_ts_tuser,
  output logic        m_axis_ts_tvalid,
  input  logic        m_axis_ts_tready,
  output logic        overflow,
  output logic        error,
  output logic [15:0] drop_count
);

  localparam int unsigned LAST    = SYNC_STAGES - 1;
  localparam tod_ns_t     NS_WRAP = tod_ns_t'(NS_PER_S);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   lvl, det;

  logic     s1_valid_q, s1_rise_q;
  tod_s_t   s1_s_q;
  tod_ns_t  s1_ns_q;
  tod_fns_t s1_fns_q;

  logic    borrow;
  tod_ns_t ns_sub, comp_ns;
  tod_s_t  comp_s;

  logic  s2_valid_q, s2_rise_q;
  ts96_t s2_ts_q;

  logic        push, pop, drop, fifo_full, fifo_empty;
  ts_event_t   push_ev, head_ev;
  logic        overflow_q, error_q;
  logic [15:0] drop_count_q;
  logic        unused_ts_bits;

  // Reserved ToD bits are regenerated as zero on output
  assign unused_ts_bits = ^input_ts_96[47:46];

  // Synchronize pulse_in and keep the previous synchronized level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      prev_q <= sync_q[LAST];
    end
  end

  assign lvl = sync_q[LAST];
  assign det = enable & ((lvl & ~prev_q & edge_sel[0]) | (~lvl & prev_q & edge_sel[1]));

  // Stage 1: latch ToD and edge type in the detect cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rise_q  <= 1'b0;
      s1_s_q     <= '0;
      s1_ns_q    <= '0;
      s1_fns_q   <= '0;
    end else begin
      s1_valid_q <= det & ~input_ts_step & ~clear;
      if (det) begin
        s1_rise_q <= lvl;
        s1_s_q    <= input_ts_96[S_MSB:S_LSB];
        s1_ns_q   <= input_ts_96[NS_MSB:NS_LSB];
        s1_fns_q  <= (FNS_ENABLE != 0) ? input_ts_96[FNS_W-1:0] : '0;
      end
    end
  end

  // Latency compensation; a borrow wraps ns into the previous second
  assign borrow  = (s1_ns_q < COMP_NS);
  assign ns_sub  = s1_ns_q - COMP_NS;
  assign comp_ns = borrow ? ns_sub + NS_WRAP : ns_sub;
  assign comp_s  = borrow ? s1_s_q - tod_s_t'(1) : s1_s_q;

  // Stage 2: hold the compensated timestamp ready for the FIFO push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_rise_q  <= 1'b0;
      s2_ts_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q & ~input_ts_step & ~clear;
      if (s1_valid_q) begin
        s2_rise_q <= s1_rise_q;
        s2_ts_q   <= ts96_pack(comp_s, comp_ns, s1_fns_q);
      end
    end
  end

  // Stage 3: push into the FIFO unless a ToD step or clear voids the event
  assign push    = s2_valid_q & ~input_ts_step & ~clear;
  assign pop     = m_axis_ts_tvalid & m_axis_ts_tready;
  assign drop    = push & fifo_full & ~pop;
  assign push_ev = '{rise: s2_rise_q, ts: s2_ts_q};

  ptp_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ts_event_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push),
    .wdata (push_ev),
    .pop   (pop),
    .rdata (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_ts_tvalid = ~fifo_empty;
  assign m_axis_ts_tdata  = head_ev.ts;
  assign m_axis_ts_tuser  = head_ev.rise;

  // Sticky status and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      error_q      <= 1'b0;
      drop_count_q <= '0;
    end else if (clear) begin
      overflow_q   <= 1'b0;
      error_q      <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
      if (input_ts_step & (det | s1_valid_q | s2_valid_q)) error_q <= 1'b1;
    end
  end

  assign overflow   = overflow_q;
  assign error      = error_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ptp_pulse_capture.sv
// Self-checking bench for ptp_pulse_capture: compensation vector table, hand-written
// corner sequences and a randomized run against an event-level reference model.
module tb_ptp_pulse_capture;
  import ptp_pkg::*;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [29:0] COMP  = 30'd24;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] input_ts_96;
  logic        input_ts_step, pulse_in, enable, clear, tready;
  logic [1:0]  edge_sel;
  logic [95:0] tdata;
  logic        tuser, tvalid, overflow, error;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  ptp_pulse_capture #(
    .FNS_ENABLE  (1),
    .SYNC_STAGES (SYNC),
    .COMP_NS     (COMP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .input_ts_96      (input_ts_96),
    .input_ts_step    (input_ts_step),
    .pulse_in         (pulse_in),
    .enable           (enable),
    .edge_sel         (edge_sel),
    .clear            (clear),
    .m_axis_ts_tdata  (tdata),
    .m_axis_ts_tuser  (tuser),
    .m_axis_ts_tvalid (tvalid),
    .m_axis_ts_tready (tready),
    .overflow         (overflow),
    .error            (error),
    .drop_count       (drop_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  typedef struct {
    int          due;
    logic [95:0] ts;
    logic        rise;
  } pend_t;
  typedef struct {
    logic [95:0] ts;
    logic        rise;
  } ev_t;

  pend_t pend[$];
  ev_t   mq[$];
  logic  ph[$];  // pulse_in as sampled at past edges, most recent first
  logic  m_ovf, m_err;
  int    m_drops;
  int    k = 0;

  function automatic logic [95:0] comp_model(input logic [95:0] t);
    logic [47:0] s;
    logic [31:0] nsx;
    logic [29:0] ns;
    s   = t[95:48];
    nsx = {2'b00, t[45:16]};
    if (nsx >= 32'(COMP)) nsx = nsx - 32'(COMP);
    else begin
      nsx = nsx + NS_PER_S - 32'(COMP);
      s   = s - 48'd1;
    end
    ns = nsx[29:0];
    return {s, 2'b00, ns, t[15:0]};
  endfunction

  task automatic model_reset();
    pend.delete();
    mq.delete();
    ph.delete();
    for (int i = 0; i <= SYNC; i++) ph.push_back(1'b0);
    m_ovf   = 1'b0;
    m_err   = 1'b0;
    m_drops = 0;
  endtask

  // Apply the effect of the coming clock edge using the currently driven inputs
  task automatic model_edge();
    logic lvl, prv, det, pop;
    lvl = ph[SYNC-1];
    prv = ph[SYNC];
    det = enable && ((lvl && !prv && edge_sel[0]) || (!lvl && prv && edge_sel[1]));
    pop = tready && (mq.size() > 0);
    if (clear) begin
      pend.delete();
      mq.delete();
      m_ovf   = 1'b0;
      m_err   = 1'b0;
      m_drops = 0;
    end else begin
      if (input_ts_step) begin
        if (det || pend.size() > 0) m_err = 1'b1;
        pend.delete();
        det = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == k) begin
        if (mq.size() < DEPTH) mq.push_back('{ts: pend[0].ts, rise: pend[0].rise});
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
        void'(pend.pop_front());
      end
      if (det) pend.push_back('{due: k + 2, ts: comp_model(input_ts_96), rise: lvl});
    end
    ph.push_front(pulse_in);
    void'(ph.pop_back());
    k++;
  endtask

  task automatic model_compare();
    check("m_tvalid", tvalid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("m_tdata", tdata, mq[0].ts);
      check("m_tuser", tuser, mq[0].rise);
    end
    check("m_overflow", overflow, m_ovf);
    check("m_error", error, m_err);
    check("m_drop_count", drop_count, 96'(m_drops));
  endtask

  // ---------------- stimulus helpers ----------------
  logic [47:0] tod_s   = '0;
  logic [29:0] tod_ns  = '0;
  logic [29:0] tod_inc = '0;

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    model_compare();
    if (tod_inc != 0) begin
      tod_ns      = tod_ns + tod_inc;
      input_ts_96 = {tod_s, 2'b00, tod_ns, 16'h0000};
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rising_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      repeat (2) tick();
      pulse_in = 1'b0;
      repeat (2) tick();
    end
  endtask

  typedef struct {
    logic [47:0] s;
    logic [29:0] ns;
    logic [15:0] fns;
    logic        rise;
    logic [47:0] exp_s;
    logic [29:0] exp_ns;
  } vec_t;

  vec_t vecs[6];

  logic [29:0] prev_ns, first_ns;
  logic [95:0] held_ts;
  logic [31:0] r1, r2, r3;
  int          lat;

  initial begin
    vecs[0] = '{s: 48'd10, ns: 30'd500, fns: 16'h1234, rise: 1'b1,
                exp_s: 48'd10, exp_ns: 30'd476};
    vecs[1] = '{s: 48'd7, ns: 30'd10, fns: 16'hBEEF, rise: 1'b1,
                exp_s: 48'd6, exp_ns: 30'd999_999_986};
    vecs[2] = '{s: 48'd0, ns: 30'd5, fns: 16'h0001, rise: 1'b0,
                exp_s: 48'hFFFF_FFFF_FFFF, exp_ns: 30'd999_999_981};
    vecs[3] = '{s: 48'd3, ns: 30'd24, fns: 16'h0000, rise: 1'b1,
                exp_s: 48'd3, exp_ns: 30'd0};
    vecs[4] = '{s: 48'd3, ns: 30'd23, fns: 16'hFFFF, rise: 1'b0,
                exp_s: 48'd2, exp_ns: 30'd999_999_999};
    vecs[5] = '{s: 48'h1234_5678_9ABC, ns: 30'd999_999_999, fns: 16'h8000, rise: 1'b1,
                exp_s: 48'h1234_5678_9ABC, exp_ns: 30'd999_999_975};

    rst           = 1'b1;
    input_ts_96   = '0;
    input_ts_step = 1'b0;
    pulse_in      = 1'b0;
    enable        = 1'b1;
    edge_sel      = 2'b01;
    clear         = 1'b0;
    tready        = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 96'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_drop_count", drop_count, 16'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Compensation vectors, including latency of the first event
    for (int i = 0; i < 6; i++) begin
      edge_sel = 2'b00;
      pulse_in = ~vecs[i].rise;
      repeat (SYNC + 3) tick();
      edge_sel    = vecs[i].rise ? 2'b01 : 2'b10;
      input_ts_96 = {vecs[i].s, 2'b11, vecs[i].ns, vecs[i].fns};
      pulse_in    = vecs[i].rise;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!tvalid && lat < 12);
      check("vec_latency", lat, SYNC + 3);
      check("vec_s", tdata[95:48], vecs[i].exp_s);
      check("vec_pad", tdata[47:46], 2'b00);
      check("vec_ns", tdata[45:16], vecs[i].exp_ns);
      check("vec_fns", tdata[15:0], vecs[i].fns);
      check("vec_tuser", tuser, vecs[i].rise);
      tready = 1'b1;
      tick();
      tready = 1'b0;
      check("vec_drained", tvalid, 1'b0);
    end

    // Falling edge ignored with edge_sel = 01
    edge_sel = 2'b01;
    pulse_in = 1'b1;
    repeat (8) tick();
    tready = 1'b1;
    tick();
    tready   = 1'b0;
    pulse_in = 1'b0;
    repeat (8) tick();
    check("fall_ignored", tvalid, 1'b0);

    // Both edges of a 3-cycle pulse, timestamps 3 increments apart
    tod_s    = 48'd20;
    tod_ns   = 30'd1000;
    tod_inc  = 30'd8;
    edge_sel = 2'b11;
    pulse_in = 1'b1;
    repeat (3) tick();
    pulse_in = 1'b0;
    repeat (8) tick();
    check("t3_valid", tvalid, 1'b1);
    check("t3_first_rise", tuser, 1'b1);
    first_ns = tdata[45:16];
    tready   = 1'b1;
    tick();
    tready = 1'b0;
    check("t3_second_fall", tuser, 1'b0);
    check("t3_delta", tdata[45:16] - first_ns, 30'd24);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("t3_empty", tvalid, 1'b0);

    // Overflow: 6 rising edges into a 4-deep FIFO with no reader
    edge_sel = 2'b01;
    do_clear();
    rising_pulses(6);
    repeat (6) tick();
    check("t4_overflow", overflow, 1'b1);
    check("t4_drop_count", drop_count, 16'd2);
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_pop_valid", tvalid, 1'b1);
      if (i > 0) check("t4_order", tdata[45:16] > prev_ns, 1'b1);
      prev_ns = tdata[45:16];
      tick();
    end
    tready = 1'b0;
    check("t4_empty", tvalid, 1'b0);

    // Full FIFO with simultaneous pop and push: nothing dropped
    do_clear();
    rising_pulses(5);
    repeat (6) tick();
    check("t5_drop_before", drop_count, 16'd1);
    pulse_in = 1'b1;
    repeat (SYNC + 2) tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    repeat (4) tick();
    check("t5_drop_after", drop_count, 16'd1);
    check("t5_valid", tvalid, 1'b1);
    pulse_in = 1'b0;
    repeat (4) tick();
    do_clear();
    check("t5_clear_valid", tvalid, 1'b0);
    check("t5_clear_overflow", overflow, 1'b0);
    check("t5_clear_drops", drop_count, 16'd0);

    // ToD step one cycle after detect discards that event only
    rising_pulses(1);
    repeat (6) tick();
    held_ts  = tdata;
    pulse_in = 1'b1;
    repeat (SYNC + 1) tick();
    input_ts_step = 1'b1;
    tick();
    input_ts_step = 1'b0;
    repeat (6) tick();
    check("t6_error", error, 1'b1);
    check("t6_kept", tdata, held_ts);
    pulse_in = 1'b0;

    // Asynchronous reset mid-stream clears outputs without a clock edge
    rst = 1'b1;
    #2;
    check("t6_rst_tvalid", tvalid, 1'b0);
    check("t6_rst_tdata", tdata, 96'd0);
    check("t6_rst_error", error, 1'b0);
    check("t6_rst_overflow", overflow, 1'b0);
    model_reset();
    rst = 1'b0;
    tod_inc = '0;
    repeat (4) tick();

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) pulse_in = ~pulse_in;
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) edge_sel = 2'($urandom_range(0, 3));
      tready        = ($urandom_range(0, 2) == 0);
      input_ts_step = ($urandom_range(0, 63) == 0);
      clear         = ($urandom_range(0, 127) == 0);
      r1 = $urandom;
      r2 = $urandom;
      r3 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 999_999_999);
      input_ts_96 = {r1[15:0], r2, r1[17:16], r3[29:0], r1[31:16]};
      tick();
    end
    input_ts_step = 1'b0;
    clear         = 1'b0;
    tready        = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
